// File: rtl/stage1_operand_fetch.sv
// Stage-1 operand fetch: resolves an operand from RAM, RAM-indirect,
// an input device or a constant, with optional request timeout.
module stage1_operand_fetch #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int IO_ADDR_WIDTH  = 8,
    parameter int SRC_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mblock_s1,
    input  logic [SRC_WIDTH-1:0]     vr_source,
    output logic                     ram_req,
    output logic [ADDR_WIDTH-1:0]    ram_address,
    input  logic                     ram_ack,
    input  logic [DATA_WIDTH-1:0]    ram_value,
    output logic                     io_req,
    output logic [IO_ADDR_WIDTH-1:0] input_devices_address,
    input  logic                     io_ack,
    input  logic [DATA_WIDTH-1:0]    input_devices_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    vr_value,
    output logic                     out_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RAM_WAIT,
        PTR_WAIT,
        IO_WAIT,
        OUT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            ptr_skip;
    logic            ram_hit;
    logic            io_hit;
    logic            expired;

    // The first cycle after a pointer load still carries the pointer read's ack.
    assign ram_hit  = ram_req && ram_ack && !ptr_skip;
    assign io_hit   = io_req && io_ack;
    assign expired  = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            cnt                   <= '0;
            ptr_skip              <= 1'b0;
            ram_req               <= 1'b0;
            io_req                <= 1'b0;
            out_valid             <= 1'b0;
            out_error             <= 1'b0;
            vr_value              <= '0;
            ram_address           <= '0;
            input_devices_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt       <= '0;
                        ptr_skip  <= 1'b0;
                        out_error <= 1'b0;
                        unique case (mblock_s1)
                            2'd0: begin
                                state       <= RAM_WAIT;
                                ram_req     <= 1'b1;
                                ram_address <= ADDR_WIDTH'(vr_source);
                            end
                            2'd1: begin
                                state       <= PTR_WAIT;
                                ram_req     <= 1'b1;
                                ram_address <= ADDR_WIDTH'(vr_source);
                            end
                            2'd2: begin
                                state  <= IO_WAIT;
                                io_req <= 1'b1;
                                input_devices_address <=
                                    IO_ADDR_WIDTH'(vr_source);
                            end
                            2'd3: begin
                                state     <= OUT;
                                out_valid <= 1'b1;
                                vr_value  <= DATA_WIDTH'(vr_source);
                            end
                        endcase
                    end
                end
                RAM_WAIT: begin
                    if (ram_hit) begin
                        state     <= OUT;
                        ram_req   <= 1'b0;
                        out_valid <= 1'b1;
                        vr_value  <= ram_value;
                    end else if (expired) begin
                        state     <= OUT;
                        ram_req   <= 1'b0;
                        ptr_skip  <= 1'b0;
                        out_valid <= 1'b1;
                        out_error <= 1'b1;
                        vr_value  <= '0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        ptr_skip <= 1'b0;
                    end
                end
                PTR_WAIT: begin
                    if (ram_hit) begin
                        state       <= RAM_WAIT;
                        cnt         <= '0;
                        ptr_skip    <= 1'b1;
                        ram_address <= ram_value[ADDR_WIDTH-1:0];
                    end else if (expired) begin
                        state     <= OUT;
                        ram_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_error <= 1'b1;
                        vr_value  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IO_WAIT: begin
                    if (io_hit) begin
                        state     <= OUT;
                        io_req    <= 1'b0;
                        out_valid <= 1'b1;
                        vr_value  <= input_devices_value;
                    end else if (expired) begin
                        state     <= OUT;
                        io_req    <= 1'b0;
                        out_valid <= 1'b1;
                        out_error <= 1'b1;
                        vr_value  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage1_operand_fetch.sv
// Directed-vector bench for stage1_operand_fetch (TIMEOUT_CYCLES=4).
module tb_stage1_operand_fetch;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mblock_s1;
    logic [7:0]  vr_source;
    logic        ram_req;
    logic [15:0] ram_address;
    logic        ram_ack;
    logic [31:0] ram_value;
    logic        io_req;
    logic [7:0]  input_devices_address;
    logic        io_ack;
    logic [31:0] input_devices_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] vr_value;
    logic        out_error;

    logic        ram_auto;
    logic        ram_ack_man;
    logic [31:0] ram_value_man;

    int total;
    int bad;

    // Auto mode: zero-latency RAM holding mem[0x10]=0x40, mem[0x40]=77.
    assign ram_ack   = ram_auto ? ram_req : ram_ack_man;
    assign ram_value = ram_auto ?
        ((ram_address == 16'h0010) ? 32'h0000_0040 :
         (ram_address == 16'h0040) ? 32'd77 : 32'hdead_beef) :
        ram_value_man;

    stage1_operand_fetch #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .IO_ADDR_WIDTH(8),
        .SRC_WIDTH(8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mblock_s1(mblock_s1),
        .vr_source(vr_source),
        .ram_req(ram_req),
        .ram_address(ram_address),
        .ram_ack(ram_ack),
        .ram_value(ram_value),
        .io_req(io_req),
        .input_devices_address(input_devices_address),
        .io_ack(io_ack),
        .input_devices_value(input_devices_value),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .vr_value(vr_value),
        .out_error(out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if ({ram_req, io_req} !== 2'b00) begin bad++; $display("FAIL rst_reqs got=%b want=00", {ram_req, io_req}); end
        total++; if (vr_value !== 32'd0) begin bad++; $display("FAIL rst_vr_value got=%0h want=0", vr_value); end
        total++; if (out_error !== 1'b0) begin bad++; $display("FAIL rst_out_error got=%0b want=0", out_error); end
        total++; if ({ram_address, input_devices_address} !== 24'd0) begin bad++; $display("FAIL rst_addrs got=%0h want=0", {ram_address, input_devices_address}); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_constant();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mblock_s1 = 2'd3;
        vr_source = 8'd33;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL const_valid got=%0b want=1", out_valid); end
        total++; if (vr_value !== 32'd33) begin bad++; $display("FAIL const_value got=%0d want=33", vr_value); end
        total++; if (out_error !== 1'b0) begin bad++; $display("FAIL const_error got=%0b want=0", out_error); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL const_busy got=%0b want=0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL const_drop got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL const_ready got=%0b want=1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_ram();
        in_valid  = 1'b1;
        mblock_s1 = 2'd0;
        vr_source = 8'd33;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL ram_req_c%0d got=%0b want=1", i, ram_req); end
            total++; if (ram_address !== 16'd33) begin bad++; $display("FAIL ram_addr_c%0d got=%0d want=33", i, ram_address); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ram_early_c%0d got=%0b want=0", i, out_valid); end
            if (i == 2) begin
                ram_ack_man   = 1'b1;
                ram_value_man = 32'd55;
            end
            tick();
        end
        ram_ack_man   = 1'b0;
        ram_value_man = 32'hffff_ffff;
        total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL ram_req_drop got=%0b want=0", ram_req); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ram_valid got=%0b want=1", out_valid); end
        total++; if (vr_value !== 32'd55) begin bad++; $display("FAIL ram_value got=%0d want=55", vr_value); end
        total++; if (out_error !== 1'b0) begin bad++; $display("FAIL ram_error got=%0b want=0", out_error); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ram_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_indirect();
        ram_auto  = 1'b1;
        in_valid  = 1'b1;
        mblock_s1 = 2'd1;
        vr_source = 8'h10;
        tick();
        in_valid = 1'b0;
        total++; if ({ram_req, ram_address} !== {1'b1, 16'h0010}) begin bad++; $display("FAIL ind_first got=%0h want=10010", {ram_req, ram_address}); end
        tick();
        total++; if ({ram_req, ram_address} !== {1'b1, 16'h0040}) begin bad++; $display("FAIL ind_second got=%0h want=10040", {ram_req, ram_address}); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ind_early1 got=%0b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ind_early2 got=%0b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ind_latency got=%0b want=1", out_valid); end
        total++; if (vr_value !== 32'd77) begin bad++; $display("FAIL ind_value got=%0d want=77", vr_value); end
        total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL ind_req_drop got=%0b want=0", ram_req); end
        ram_auto  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_io_backpressure();
        in_valid  = 1'b1;
        mblock_s1 = 2'd2;
        vr_source = 8'd33;
        tick();
        in_valid = 1'b0;
        total++; if (io_req !== 1'b1) begin bad++; $display("FAIL io_req got=%0b want=1", io_req); end
        total++; if (input_devices_address !== 8'd33) begin bad++; $display("FAIL io_addr got=%0d want=33", input_devices_address); end
        total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL io_ram_req got=%0b want=0", ram_req); end
        io_ack              = 1'b1;
        input_devices_value = 32'd22;
        tick();
        io_ack              = 1'b0;
        input_devices_value = 32'd99;
        // A competing command must not be taken while the result is held.
        in_valid  = 1'b1;
        mblock_s1 = 2'd3;
        vr_source = 8'd5;
        for (int i = 0; i < 5; i++) begin
            total++; if ({out_valid, vr_value} !== {1'b1, 32'd22}) begin bad++; $display("FAIL io_hold_c%0d got=%0h want=100000016", i, {out_valid, vr_value}); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL io_busy_c%0d got=%0b want=0", i, in_ready); end
            if (i == 4) in_valid = 1'b0;
            tick();
        end
        total++; if (io_req !== 1'b0) begin bad++; $display("FAIL io_req_drop got=%0b want=0", io_req); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL io_release got=%b want=10", {in_ready, out_valid}); end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            in_valid  = 1'b1;
            mblock_s1 = 2'd0;
            vr_source = 8'd7;
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                total++; if ({ram_req, out_valid} !== 2'b10) begin bad++; $display("FAIL to%0d_wait_c%0d got=%b want=10", pass, i, {ram_req, out_valid}); end
                if (pass == 1 && i == 3) begin
                    ram_ack_man   = 1'b1;
                    ram_value_man = 32'h0000_1234;
                end
                tick();
            end
            ram_ack_man = 1'b0;
            total++; if ({ram_req, out_valid} !== 2'b01) begin bad++; $display("FAIL to%0d_end got=%b want=01", pass, {ram_req, out_valid}); end
            if (pass == 0) begin
                total++; if ({out_error, vr_value} !== {1'b1, 32'd0}) begin bad++; $display("FAIL to_error got=%0h want=100000000", {out_error, vr_value}); end
            end else begin
                total++; if ({out_error, vr_value} !== {1'b0, 32'h1234}) begin bad++; $display("FAIL to_ack_wins got=%0h want=1234", {out_error, vr_value}); end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] srcs [3];
        srcs[0] = 8'd1;
        srcs[1] = 8'hff;
        srcs[2] = 8'h80;
        out_ready = 1'b1;
        mblock_s1 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            vr_source = srcs[i];
            tick();
            total++; if ({out_valid, vr_value} !== {1'b1, 24'd0, srcs[i]}) begin bad++; $display("FAIL b2b_%0d got=%0h want=%0h", i, {out_valid, vr_value}, {1'b1, 24'd0, srcs[i]}); end
            tick();
            total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL b2b_idle_%0d got=%b want=10", i, {in_ready, out_valid}); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid  = 1'b1;
        mblock_s1 = 2'd1;
        vr_source = 8'h10;
        tick();
        in_valid = 1'b0;
        total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL rm_req got=%0b want=1", ram_req); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({ram_req, out_valid} !== 2'b00) begin bad++; $display("FAIL rm_async got=%b want=00", {ram_req, out_valid}); end
        ram_ack_man   = 1'b1;
        ram_value_man = 32'd88;
        tick();
        reset_n = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%0b want=1", in_ready); end
        tick();
        tick();
        total++; if ({in_ready, out_valid, ram_req} !== 3'b100) begin bad++; $display("FAIL rm_stale_ack got=%b want=100", {in_ready, out_valid, ram_req}); end
        total++; if (vr_value !== 32'd0) begin bad++; $display("FAIL rm_value got=%0d want=0", vr_value); end
        ram_ack_man = 1'b0;
    endtask

    initial begin
        total               = 0;
        bad                 = 0;
        reset_n             = 1'b0;
        in_valid            = 1'b0;
        mblock_s1           = 2'd0;
        vr_source           = 8'd0;
        out_ready           = 1'b0;
        ram_auto            = 1'b0;
        ram_ack_man         = 1'b0;
        ram_value_man       = 32'd0;
        io_ack              = 1'b0;
        input_devices_value = 32'd0;
        test_reset();
        test_constant();
        test_ram();
        test_indirect();
        test_io_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
